// File: rtl/riscv_pkg.sv
// Shared integer-register-file definitions.
// Contents:
//   XLEN       - default register width in bits
//   NREGS      - default number of architectural registers
//   AW         - register address width derived from NREGS
//   reg_addr_t - register address type
//   REG_ZERO   - the hard-wired zero register
package riscv_pkg;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  typedef logic [AW-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/busy_scoreboard.sv
// Busy-bit scoreboard for the register file.
// It holds one busy bit per register and flags read-after-write and
// write-after-write hazards against registers whose long-latency result is
// still outstanding.
// Ports:
//   clk_i, rst_i             - clock, synchronous active-high reset
//   set_en_i, set_addr_i     - mark a register busy at the next edge
//   clr_en_i, clr_addr_i     - load completing; clears the bit at the next edge
//                              and is already treated as not busy this cycle
//   rs1_en_i, rs1_addr_i     - source operand 1 check
//   rs2_en_i, rs2_addr_i     - source operand 2 check
//   rd_en_i,  rd_addr_i      - destination check (write-after-write)
//   busy_o                   - registered busy vector
//   hazard_o                 - any enabled check hits a busy register
module busy_scoreboard #(
  parameter  int NREGS = riscv_pkg::NREGS,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             set_en_i,
  input  logic [AW-1:0]    set_addr_i,
  input  logic             clr_en_i,
  input  logic [AW-1:0]    clr_addr_i,
  input  logic             rs1_en_i,
  input  logic [AW-1:0]    rs1_addr_i,
  input  logic             rs2_en_i,
  input  logic [AW-1:0]    rs2_addr_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [NREGS-1:0] busy_o,
  output logic             hazard_o
);

  localparam logic [AW-1:0] ZERO_A = AW'(riscv_pkg::REG_ZERO);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] busy_eff;

  // A load finishing this cycle no longer blocks: its data is forwarded by
  // the register file's bypass, so it is removed before the hazard compare.
  always_comb begin
    busy_eff = busy_q;
    if (clr_en_i) busy_eff[clr_addr_i] = 1'b0;
  end

  always_comb begin
    hazard_o = (rs1_en_i && busy_eff[rs1_addr_i]) ||
               (rs2_en_i && busy_eff[rs2_addr_i]) ||
               (rd_en_i  && busy_eff[rd_addr_i]);
  end

  // Set is applied after clear so a new long op to the same register wins.
  always_comb begin
    busy_d = busy_eff;
    if (set_en_i && (set_addr_i != ZERO_A)) busy_d[set_addr_i] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file with scoreboard.
// Two combinational read ports with same-cycle bypass, a single-cycle (ALU)
// write port, a long-latency (load) write port and a busy-bit scoreboard that
// withholds issue while a needed register is still waiting on a load.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   rs1_addr/rs2_addr, rsN_used    - read addresses and operand-used flags
//   rs1_data/rs2_data              - bypassed read data
//   iss_valid, iss_ready           - issue handshake (ready ignores valid)
//   iss_rd, iss_rd_en, iss_rd_long - destination of the issuing instruction
//   wb_en/wb_addr/wb_data          - single-cycle write port
//   ld_en/ld_addr/ld_data          - long-latency write port, clears busy
//   busy                           - scoreboard vector
module reg_file_sb #(
  parameter  int XLEN  = riscv_pkg::XLEN,
  parameter  int NREGS = riscv_pkg::NREGS,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rs1_addr,
  input  logic [AW-1:0]    rs2_addr,
  input  logic             rs1_used,
  input  logic             rs2_used,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  input  logic             iss_valid,
  output logic             iss_ready,
  input  logic [AW-1:0]    iss_rd,
  input  logic             iss_rd_en,
  input  logic             iss_rd_long,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [XLEN-1:0]  ld_data,
  output logic [NREGS-1:0] busy
);

  localparam logic [AW-1:0] ZERO_A = AW'(riscv_pkg::REG_ZERO);

  logic [XLEN-1:0] regs_q [NREGS];
  logic            hazard;
  logic            set_en;

  // Writes to x0 are dropped, so regs_q[0] stays at its reset value of 0.
  // When both ports hit the same register the load write is issued last
  // and therefore takes effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      if (wb_en && (wb_addr != ZERO_A)) regs_q[wb_addr] <= wb_data;
      if (ld_en && (ld_addr != ZERO_A)) regs_q[ld_addr] <= ld_data;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] a);
    if (a == ZERO_A)                 return '0;
    else if (ld_en && (ld_addr == a)) return ld_data;
    else if (wb_en && (wb_addr == a)) return wb_data;
    else                             return regs_q[a];
  endfunction

  always_comb begin
    rs1_data = read_port(rs1_addr);
    rs2_data = read_port(rs2_addr);
  end

  // Ready depends only on the scoreboard, never on iss_valid, so the decoder
  // can use it to qualify its own valid without a combinational loop.
  assign iss_ready = !rst && !hazard;
  assign set_en    = iss_valid && iss_ready && iss_rd_en && iss_rd_long;

  busy_scoreboard #(
    .NREGS (NREGS)
  ) u_sb (
    .clk_i      (clk),
    .rst_i      (rst),
    .set_en_i   (set_en),
    .set_addr_i (iss_rd),
    .clr_en_i   (ld_en),
    .clr_addr_i (ld_addr),
    .rs1_en_i   (rs1_used),
    .rs1_addr_i (rs1_addr),
    .rs2_en_i   (rs2_used),
    .rs2_addr_i (rs2_addr),
    .rd_en_i    (iss_rd_en),
    .rd_addr_i  (iss_rd),
    .busy_o     (busy),
    .hazard_o   (hazard)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios followed by
// random traffic, compared each cycle against a behavioural model.
module tb_reg_file_sb;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic [AW-1:0]    rs1_addr, rs2_addr;
  logic             rs1_used, rs2_used;
  logic [XLEN-1:0]  rs1_data, rs2_data;
  logic             iss_valid, iss_ready;
  logic [AW-1:0]    iss_rd;
  logic             iss_rd_en, iss_rd_long;
  logic             wb_en;
  logic [AW-1:0]    wb_addr;
  logic [XLEN-1:0]  wb_data;
  logic             ld_en;
  logic [AW-1:0]    ld_addr;
  logic [XLEN-1:0]  ld_data;
  logic [NREGS-1:0] busy;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  logic [XLEN-1:0] m_reg  [NREGS];
  bit              m_busy [NREGS];

  always #5 clk = ~clk;

  reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rd(iss_rd), .iss_rd_en(iss_rd_en), .iss_rd_long(iss_rd_long),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Model: a register that is being loaded this cycle no longer counts as busy.
  function automatic bit m_blocked(input logic [AW-1:0] a);
    return m_busy[a] && !(ld_en && ld_addr == a);
  endfunction

  function automatic bit m_ready();
    if (rst) return 0;
    if (rs1_used && m_blocked(rs1_addr)) return 0;
    if (rs2_used && m_blocked(rs2_addr)) return 0;
    if (iss_rd_en && m_blocked(iss_rd)) return 0;
    return 1;
  endfunction

  function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (ld_en && ld_addr == a) return ld_data;
    if (wb_en && wb_addr == a) return wb_data;
    return m_reg[a];
  endfunction

  function automatic logic [NREGS-1:0] m_busy_vec();
    logic [NREGS-1:0] v;
    for (int i = 0; i < NREGS; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic idle();
    rst = 0; rs1_addr = 0; rs2_addr = 0; rs1_used = 0; rs2_used = 0;
    iss_valid = 0; iss_rd = 0; iss_rd_en = 0; iss_rd_long = 0;
    wb_en = 0; wb_addr = 0; wb_data = '0;
    ld_en = 0; ld_addr = 0; ld_data = '0;
  endtask

  // Compare all outputs against the model, away from the rising edge.
  task automatic sample();
    @(negedge clk);
    check("rs1_data", rs1_data, m_read(rs1_addr));
    check("rs2_data", rs2_data, m_read(rs2_addr));
    check("iss_ready", XLEN'(iss_ready), XLEN'(m_ready()));
    check("busy", XLEN'(busy), XLEN'(m_busy_vec()));
  endtask

  // Advance the model across the rising edge, then release inputs.
  task automatic tick();
    bit accept;
    @(posedge clk);
    accept = iss_valid && m_ready();
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        m_reg[i] = '0;
        m_busy[i] = 0;
      end
    end else begin
      if (wb_en && wb_addr != 0) m_reg[wb_addr] = wb_data;
      if (ld_en && ld_addr != 0) m_reg[ld_addr] = ld_data;
      if (ld_en) m_busy[ld_addr] = 0;
      if (accept && iss_rd_en && iss_rd_long && iss_rd != 0) m_busy[iss_rd] = 1;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) begin
      m_reg[i] = '0;
      m_busy[i] = 0;
    end
    idle();
    rst = 1;
    sample(); tick();
    sample(); check("rst_ready", XLEN'(iss_ready), '0); tick();
    idle();

    // After reset: all registers read 0, nothing busy, ready high.
    for (int i = 1; i < NREGS; i++) begin
      rs1_addr = AW'(i); rs2_addr = AW'(NREGS - i);
      sample();
      check("rst_x", rs1_data, '0);
      tick();
    end
    check("rst_busy", XLEN'(busy), '0);
    check("rst_rdy1", XLEN'(iss_ready), XLEN'(1));

    // ALU write bypass, then array read, then x0 ignored.
    wb_en = 1; wb_addr = 5; wb_data = 64'h0123_4567_89AB_CDEF; rs1_addr = 5;
    sample(); check("wb_bypass", rs1_data, 64'h0123_4567_89AB_CDEF); tick();
    idle(); rs1_addr = 5;
    sample(); check("wb_array", rs1_data, 64'h0123_4567_89AB_CDEF); tick();
    wb_en = 1; wb_addr = 0; wb_data = '1; rs1_addr = 0;
    sample(); check("x0_bypass", rs1_data, '0); tick();
    idle();
    sample(); check("x0_array", rs1_data, '0); tick();

    // Long load to x7, dependent consumer stalls until the load returns.
    iss_valid = 1; iss_rd_en = 1; iss_rd_long = 1; iss_rd = 7;
    sample(); tick();
    idle();
    iss_valid = 1; rs2_used = 1; rs2_addr = 7;
    sample(); check("busy7", XLEN'(busy[7]), XLEN'(1));
    check("stall0", XLEN'(iss_ready), '0); tick();
    sample(); check("stall1", XLEN'(iss_ready), '0); tick();
    ld_en = 1; ld_addr = 7; ld_data = 64'h55;
    sample(); check("ld_use_rdy", XLEN'(iss_ready), XLEN'(1));
    check("ld_use_data", rs2_data, 64'h55); tick();
    idle();
    sample(); check("busy7_clr", XLEN'(busy[7]), '0); tick();

    // Clear and set of x9 in the same cycle: set wins.
    iss_valid = 1; iss_rd_en = 1; iss_rd_long = 1; iss_rd = 9;
    ld_en = 1; ld_addr = 9; ld_data = 64'h99;
    sample(); tick();
    idle();
    sample(); check("busy9_set", XLEN'(busy[9]), XLEN'(1)); tick();
    ld_en = 1; ld_addr = 9; ld_data = 64'h9A;
    sample(); tick();
    idle();

    // Both ports write x3: load wins for bypass and array.
    wb_en = 1; wb_addr = 3; wb_data = 64'h11;
    ld_en = 1; ld_addr = 3; ld_data = 64'h22; rs1_addr = 3;
    sample(); check("x3_bypass", rs1_data, 64'h22); tick();
    idle(); rs1_addr = 3;
    sample(); check("x3_array", rs1_data, 64'h22); tick();

    // Reset discards an outstanding load to x4.
    iss_valid = 1; iss_rd_en = 1; iss_rd_long = 1; iss_rd = 4;
    sample(); tick();
    idle();
    sample(); check("busy4", XLEN'(busy[4]), XLEN'(1)); tick();
    rst = 1; iss_valid = 1; rs1_addr = 3;
    sample(); check("rst_mid_rdy", XLEN'(iss_ready), '0); tick();
    idle(); rs1_addr = 3;
    sample(); check("rst_mid_busy", XLEN'(busy), '0);
    check("rst_mid_x3", rs1_data, '0);
    check("rst_mid_rdy1", XLEN'(iss_ready), XLEN'(1)); tick();

    // Random traffic against the model; addresses biased to a few registers
    // so hazards, collisions and x0 accesses occur often.
    for (int c = 0; c < 600; c++) begin
      bit narrow;
      narrow = ($urandom_range(0, 3) != 0);
      rst         = ($urandom_range(0, 79) == 0);
      rs1_addr    = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
      rs2_addr    = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
      rs1_used    = $urandom_range(0, 1);
      rs2_used    = $urandom_range(0, 1);
      iss_valid   = $urandom_range(0, 1);
      iss_rd      = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
      iss_rd_en   = $urandom_range(0, 1);
      iss_rd_long = $urandom_range(0, 1);
      wb_en       = $urandom_range(0, 1);
      wb_addr     = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
      wb_data     = {$urandom, $urandom};
      ld_en       = ($urandom_range(0, 2) == 0);
      ld_addr     = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
      ld_data     = {$urandom, $urandom};
      sample();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
